// File: rtl/xoshiro32pp_checker.sv
// xoshiro32pp_checker: regenerates the xoshiro32++ 16-bit stream from matching seeds,
// aligns to the incoming words and counts compared words and mismatches once locked.
module xoshiro32pp_checker #(
    parameter logic [15:0] S0       = 16'd1,
    parameter logic [15:0] S1       = 16'd2,
    parameter int          LOCK_CNT = 4,
    parameter int          LOSS_CNT = 8,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int k);
        return (x << k) | (x >> (16 - k));
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      s0_q, s0_d, s1_q, s1_d, exp_w, t_w, adv0_w, adv1_w;
    logic [7:0]       match_cnt_q, match_cnt_d, miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d, err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d, word_count_q, word_count_d;
    logic             match, lock_hit, loss_hit;

    always_comb begin
        exp_w    = rotl(s0_q + s1_q, 9) + s0_q;
        t_w      = s0_q ^ s1_q;
        adv0_w   = rotl(s0_q, 13) ^ t_w ^ (t_w << 5);
        adv1_w   = rotl(t_w, 10);
        match    = in_data == exp_w;
        lock_hit = match_cnt_q + 8'd1 == 8'(LOCK_CNT);
        loss_hit = miss_cnt_q + 8'd1 == 8'(LOSS_CNT);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= SEARCH;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (clear) state_d = SEARCH;
        else if (in_valid)
            case (state_q)
                SEARCH:  if (match) state_d = (LOCK_CNT == 1) ? LOCKED : ACQUIRE;
                ACQUIRE: state_d = !match ? SEARCH : lock_hit ? LOCKED : ACQUIRE;
                LOCKED:  if (!match && loss_hit) state_d = SEARCH;
                default: state_d = SEARCH;
            endcase
    end

    // Any accepted word either advances the generator or, when heading to SEARCH, reseeds it.
    always_comb begin
        s0_d         = s0_q;
        s1_d         = s1_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        err_pulse_d  = 1'b0;
        locked_d     = state_d == LOCKED;
        if (clear) begin
            s0_d         = S0;
            s1_d         = S1;
            match_cnt_d  = '0;
            miss_cnt_d   = '0;
            err_count_d  = '0;
            word_count_d = '0;
        end else if (in_valid) begin
            s0_d        = state_d == SEARCH ? S0 : adv0_w;
            s1_d        = state_d == SEARCH ? S1 : adv1_w;
            match_cnt_d = state_d == SEARCH ? 8'd0 : state_q == LOCKED ? match_cnt_q : match_cnt_q + 8'd1;
            miss_cnt_d  = (state_q == LOCKED && !match && state_d == LOCKED) ? miss_cnt_q + 8'd1 : 8'd0;
            if (state_q == LOCKED) begin
                word_count_d = &word_count_q ? word_count_q : word_count_q + CNT_W'(1);
                if (!match) begin
                    err_count_d = &err_count_q ? err_count_q : err_count_q + CNT_W'(1);
                    err_pulse_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s0_q         <= S0;
            s1_q         <= S1;
            match_cnt_q  <= '0;
            miss_cnt_q   <= '0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
endmodule

// File: tb/tb_xoshiro32pp_checker.sv
// tb_xoshiro32pp_checker: directed bench for xoshiro32pp_checker with a small reference
// generator supplying the stream beyond the hand-computed first words 0x0601/0xE6BB/0x44B0.
module tb_xoshiro32pp_checker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        locked, err_pulse;
    logic [31:0] err_count, word_count;
    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_s0, m_s1;

    xoshiro32pp_checker dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rl(input logic [15:0] x, input int k);
        return (x << k) | (x >> (16 - k));
    endfunction

    function automatic logic [15:0] mexp();
        return rl(m_s0 + m_s1, 9) + m_s0;
    endfunction

    task automatic madv();
        logic [15:0] t;
        t    = m_s0 ^ m_s1;
        m_s0 = rl(m_s0, 13) ^ t ^ (t << 5);
        m_s1 = rl(t, 10);
    endtask

    task automatic reseed();
        m_s0 = 16'd1;
        m_s1 = 16'd2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_good();
        step(1'b1, mexp());
        madv();
    endtask

    task automatic send_bad();
        step(1'b1, mexp() ^ 16'h0001);
        madv();
    endtask

    task automatic relock(input string tag);
        reseed();
        for (int i = 0; i < 3; i++) send_good();
        chk({tag, "_pre"}, locked, 0);
        send_good();
        chk(tag, locked, 1);
    endtask

    initial begin
        #2;
        chk("rst_locked", locked, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_word_count", word_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First acquisition with the hand-computed words.
        reseed();
        step(1'b1, 16'h0601); madv();
        chk("acq1_locked", locked, 0);
        step(1'b1, 16'hE6BB); madv();
        step(1'b1, 16'h44B0); madv();
        chk("acq3_locked", locked, 0);
        send_good();
        chk("acq4_locked", locked, 1);
        chk("acq4_word_count", word_count, 0);
        chk("acq4_err_count", err_count, 0);

        // 100 correct words with random idle gaps.
        for (int n = 0; n < 100;) begin
            if ($urandom_range(0, 1) == 1) begin
                send_good();
                n++;
            end else step(1'b0, 16'($urandom));
            chk("run_err_pulse", err_pulse, 0);
        end
        chk("run_word_count", word_count, 100);
        chk("run_err_count", err_count, 0);
        chk("run_locked", locked, 1);

        // Single corrupted word.
        send_bad();
        chk("one_err_pulse", err_pulse, 1);
        chk("one_err_count", err_count, 1);
        chk("one_locked", locked, 1);
        step(1'b0, 16'h0000);
        chk("one_pulse_clear", err_pulse, 0);
        for (int i = 0; i < 5; i++) send_good();
        chk("one_after_err_count", err_count, 1);
        chk("one_after_word_count", word_count, 106);
        chk("one_after_pulse", err_pulse, 0);

        // Eight consecutive corruptions drop lock on the eighth.
        for (int i = 0; i < 7; i++) send_bad();
        chk("loss7_locked", locked, 1);
        send_bad();
        chk("loss8_locked", locked, 0);
        chk("loss8_err_count", err_count, 9);
        chk("loss8_word_count", word_count, 114);
        relock("relock_after_loss");
        chk("relock_word_count", word_count, 114);

        // Clear with a valid word present: word discarded, everything zeroed.
        clear = 1'b1;
        step(1'b1, mexp());
        clear = 1'b0;
        chk("clr_locked", locked, 0);
        chk("clr_err_count", err_count, 0);
        chk("clr_word_count", word_count, 0);

        // Aborted acquisition returns to SEARCH.
        step(1'b1, 16'h0601);
        step(1'b1, 16'hE6BB);
        step(1'b1, 16'h1234);
        chk("abort_locked", locked, 0);
        chk("abort_word_count", word_count, 0);
        // The mismatching E0 repeat must not restart acquisition.
        step(1'b1, 16'h0601);
        step(1'b1, 16'h0601);
        step(1'b1, 16'hE6BB);
        step(1'b1, 16'h44B0);
        reseed();
        for (int i = 0; i < 3; i++) madv();
        step(1'b1, mexp());
        chk("noretest_locked", locked, 0);

        // Lock, accumulate 3 errors, then clear mid-stream.
        relock("relock_clr");
        for (int i = 0; i < 3; i++) begin send_good(); send_bad(); end
        chk("pre_clr_err_count", err_count, 3);
        clear = 1'b1;
        step(1'b0, 16'h0000);
        clear = 1'b0;
        chk("clr2_locked", locked, 0);
        chk("clr2_err_count", err_count, 0);
        chk("clr2_word_count", word_count, 0);
        relock("relock_after_clr");

        // Async reset mid-lock.
        for (int i = 0; i < 3; i++) begin send_bad(); send_good(); end
        chk("pre_rst_err_count", err_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_word_count", word_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        relock("relock_after_rst");
        chk("relock_rst_word_count", word_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
